// File: rtl/arb_requester.sv
// arb_requester: requester-side agent for the two-device r/g arbiter.
// Define ARB_REQ_TIMEOUT_EN to add the TMO parameter and the tmo pulse output.
module arb_requester #(
    parameter int LW = 4,
    parameter int WW = 8
`ifdef ARB_REQ_TIMEOUT_EN
    ,
    parameter int TMO = 16
`endif
) (
    input  logic          ck,
    input  logic          rst_n,
    input  logic          start,
    input  logic [LW-1:0] len,
    input  logic          grant,
    output logic          req,
    output logic          act,
    output logic          busy,
    output logic          done,
    output logic          err,
`ifdef ARB_REQ_TIMEOUT_EN
    output logic          tmo,
`endif
    output logic [WW-1:0] wait_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_USE,
        S_REL
    } state_t;

    localparam logic [WW-1:0] WAIT_MAX = '1;
    localparam logic [LW-1:0] ONE      = LW'(1);

    state_t        state, state_d;
    logic [LW-1:0] cnt, cnt_d;
    logic [WW-1:0] wait_d;
    logic          err_d;
    logic          tmo_d;

    // cnt holds the effective length while in REQ, then counts down in USE
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        wait_d  = wait_cnt;
        err_d   = err;
        tmo_d   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_d = S_REQ;
                    cnt_d   = (len == '0) ? ONE : len;
                    wait_d  = '0;
                end
            end
            S_REQ: begin
                if (grant) begin
                    state_d = S_USE;
                    cnt_d   = cnt - ONE;
                end else begin
                    if (wait_cnt != WAIT_MAX) begin
                        wait_d = wait_cnt + 1'b1;
                    end
`ifdef ARB_REQ_TIMEOUT_EN
                    if (wait_cnt == WW'(TMO - 1)) begin
                        state_d = S_REL;
                        tmo_d   = 1'b1;
                    end
`endif
                end
            end
            S_USE: begin
                if (!grant) begin
                    state_d = S_REL;
                    err_d   = 1'b1;
                end else if (cnt == '0) begin
                    state_d = S_REL;
                end else begin
                    cnt_d = cnt - ONE;
                end
            end
            S_REL: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // outputs are decoded from the next state so every one is a flop
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            wait_cnt <= '0;
            err      <= 1'b0;
            req      <= 1'b0;
            act      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef ARB_REQ_TIMEOUT_EN
            tmo      <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            wait_cnt <= wait_d;
            err      <= err_d;
            req      <= (state_d == S_REQ) || (state_d == S_USE);
            act      <= (state_d == S_USE);
            busy     <= (state_d != S_IDLE);
            done     <= (state_d == S_REL) && !tmo_d;
`ifdef ARB_REQ_TIMEOUT_EN
            tmo      <= tmo_d;
`endif
        end
    end

endmodule

// File: tb/tb_arb_requester.sv
// tb_arb_requester: directed and random jobs against a per-job timeline model.
// Timeout checks are compiled in when ARB_REQ_TIMEOUT_EN is defined.
module tb_arb_requester;

    localparam int LW = 4;
    localparam int WW = 8;
`ifdef ARB_REQ_TIMEOUT_EN
    localparam int TMO = 4;
    localparam int WRND = 3;
`else
    localparam int WRND = 6;
`endif

    logic          ck = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] len = '0;
    logic          grant = 1'b0;
    logic          req, act, busy, done, err;
    logic [WW-1:0] wait_cnt;
`ifdef ARB_REQ_TIMEOUT_EN
    logic          tmo;
`endif

    int total = 0;
    int bad = 0;
    bit err_m = 1'b0;
    int w_prev = 0;

    arb_requester #(
        .LW(LW),
        .WW(WW)
`ifdef ARB_REQ_TIMEOUT_EN
        ,
        .TMO(TMO)
`endif
    ) dut (
        .ck(ck),
        .rst_n(rst_n),
        .start(start),
        .len(len),
        .grant(grant),
        .req(req),
        .act(act),
        .busy(busy),
        .done(done),
        .err(err),
`ifdef ARB_REQ_TIMEOUT_EN
        .tmo(tmo),
`endif
        .wait_cnt(wait_cnt)
    );

    always #5 ck = ~ck;

    function automatic int sat(input int x);
        return (x > 255) ? 255 : x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string ph, input bit r, input bit a,
                              input bit b, input bit d, input bit e,
                              input int w);
        chk({ph, ".req"}, 32'(req), 32'(r));
        chk({ph, ".act"}, 32'(act), 32'(a));
        chk({ph, ".busy"}, 32'(busy), 32'(b));
        chk({ph, ".done"}, 32'(done), 32'(d));
        chk({ph, ".err"}, 32'(err), 32'(e));
        chk({ph, ".wait"}, 32'(wait_cnt), 32'(w));
`ifdef ARB_REQ_TIMEOUT_EN
        chk({ph, ".tmo"}, 32'(tmo), 32'd0);
`endif
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    // Timeline in cycles after the start edge (cycle 1 = first req cycle):
    // grant low for w cycles, high on cycle w+1, act on w+2 .. t_last,
    // done on t_last+1. A drop at USE index dpos ends act on that cycle.
    task automatic run_job(input int l, input int w, input bit drop,
                           input int dpos);
        int le;
        int t_last;
        int t_done;
        le = (l == 0) ? 1 : l;
        t_last = drop ? (w + 2 + dpos) : (w + 1 + le);
        t_done = t_last + 1;
        start = 1'b1;
        len = LW'(l);
        grant = 1'($urandom);
        tick();
        for (int k = 1; k <= t_done; k++) begin
            if (drop && k == t_done) err_m = 1'b1;
            check_outs("job", k <= t_last, (k >= w + 2) && (k <= t_last),
                       1'b1, k == t_done, err_m,
                       (k <= w + 1) ? sat(k - 1) : sat(w));
            start = 1'($urandom);
            len = LW'($urandom);
            if (k <= w) grant = 1'b0;
            else if (k == w + 1) grant = 1'b1;
            else if (k <= t_last) grant = !(drop && (k - (w + 2)) == dpos);
            else grant = 1'($urandom);
            tick();
        end
        start = 1'b0;
        check_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0, err_m, sat(w));
        w_prev = w;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            start = 1'b0;
            grant = 1'($urandom);
            tick();
            check_outs("gap", 1'b0, 1'b0, 1'b0, 1'b0, err_m, sat(w_prev));
        end
    endtask

    initial begin
        int l, w, dp, le;
        bit dr;
        #1 rst_n = 1'b0;
        #1;
        check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        repeat (2) @(posedge ck);
        #3 rst_n = 1'b1;
        tick();
        check_outs("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        run_job(3, 1, 1'b0, 0);
        idle_cycles(1);
        run_job(2, 5, 1'b0, 0);
        idle_cycles(2);
        run_job(0, 0, 1'b0, 0);
        run_job(0, 0, 1'b0, 0);
        run_job(0, 2, 1'b0, 0);
        idle_cycles(1);
        run_job(4, 1, 1'b1, 1);
        run_job(3, 0, 1'b0, 0);
        idle_cycles(1);
        run_job(15, 0, 1'b0, 0);
        run_job(4, 2, 1'b1, 0);
`ifndef ARB_REQ_TIMEOUT_EN
        run_job(1, 300, 1'b0, 0);
`endif
        idle_cycles(1);

        for (int j = 0; j < 40; j++) begin
            l = $urandom_range(0, 15);
            w = $urandom_range(0, WRND);
            le = (l == 0) ? 1 : l;
            dr = ($urandom_range(0, 3) == 0);
            dp = $urandom_range(0, le - 1);
            run_job(l, w, dr, dp);
            idle_cycles($urandom_range(0, 2));
        end

        // asynchronous reset in the middle of USE
        start = 1'b1;
        len = LW'(5);
        grant = 1'b0;
        tick();
        start = 1'b0;
        grant = 1'b1;
        tick();
        tick();
        chk("mid_use.act", 32'(act), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_outs("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        #1 rst_n = 1'b1;
        err_m = 1'b0;
        w_prev = 0;
        tick();
        check_outs("after_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        idle_cycles(2);
        run_job(2, 1, 1'b0, 0);

`ifdef ARB_REQ_TIMEOUT_EN
        start = 1'b1;
        len = LW'(2);
        grant = 1'b0;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk("tmo_wait.req", 32'(req), 32'd1);
            chk("tmo_wait.tmo", 32'(tmo), 32'd0);
            tick();
        end
        chk("tmo.req", 32'(req), 32'd0);
        chk("tmo.tmo", 32'(tmo), 32'd1);
        chk("tmo.done", 32'(done), 32'd0);
        chk("tmo.busy", 32'(busy), 32'd1);
        tick();
        chk("tmo_end.busy", 32'(busy), 32'd0);
        chk("tmo_end.tmo", 32'(tmo), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            grant = (k == 4);
            tick();
        end
        chk("late_grant.act", 32'(act), 32'd1);
        chk("late_grant.tmo", 32'(tmo), 32'd0);
        tick();
        tick();
        chk("late_grant.done", 32'(done), 32'd1);
        chk("late_grant.tmo2", 32'(tmo), 32'd0);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
